// File: rtl/conv_result_streamer.sv
// Captures conv_12x12 results, requantizes them to signed 16-bit and replays them
// as a valid/ready pixel stream on finish. Define RELU_EN to clamp negative pixels to zero.
module conv_result_streamer #(
  parameter int DEPTH = 100,
  parameter int SHIFT = 8,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   in_data,
  input  logic          in_invalid,
  input  logic          in_finish,
  input  logic          out_ready,
  output logic [15:0]   output_port,
  output logic          valid,
  output logic          done,
  output logic          overflow,
  output logic [AW-1:0] count
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DRAIN   = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] count_q, count_d;
  logic [15:0]   out_q, out_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   mem [DEPTH];
  logic [15:0]   q_in_s;
  logic          cap_s;
  logic          xfer_s;
  logic [AW-1:0] rnext_s;

  // Arithmetic shift floors toward -inf; saturation keeps the pixel in int16 range.
  function automatic logic [15:0] requant(input logic [31:0] d);
    logic signed [31:0] q;
    q = $signed(d) >>> SHIFT;
`ifdef RELU_EN
    if (q < 32'sd0) begin
      q = 32'sd0;
    end else begin
      q = q;
    end
`endif
    if (q > 32'sd32767) begin
      return 16'h7FFF;
    end else if (q < -32'sd32768) begin
      return 16'h8000;
    end else begin
      return q[15:0];
    end
  endfunction

  assign q_in_s  = requant(in_data);
  assign cap_s   = (state_q == S_COLLECT) && !in_invalid && (count_q < AW'(DEPTH));
  assign xfer_s  = valid_q && out_ready;
  assign rnext_s = rptr_q + AW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: begin
        if (in_finish) begin
          state_d = ((count_q != AW'(0)) || cap_s) ? S_DRAIN : S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DRAIN: begin
        if (xfer_s && (rnext_s == count_q)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_COLLECT;
      default: state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    out_d   = out_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    // Any presented word that is not captured is lost for good.
    ovf_d   = ovf_q | (!in_invalid && !cap_s);
    case (state_q)
      S_COLLECT: begin
        if (cap_s) begin
          wptr_d  = wptr_q + AW'(1);
          count_d = count_q + AW'(1);
        end else begin
          wptr_d  = wptr_q;
        end
        if (in_finish && ((count_q != AW'(0)) || cap_s)) begin
          valid_d = 1'b1;
          rptr_d  = AW'(0);
          // An empty buffer means word 0 is the one arriving right now.
          out_d   = (count_q == AW'(0)) ? q_in_s : mem[0];
        end else if (in_finish) begin
          done_d  = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (xfer_s) begin
          rptr_d = rnext_s;
          if (rnext_s == count_q) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            out_d   = mem[rnext_s];
          end
        end else begin
          rptr_d = rptr_q;
        end
      end
      S_DONE: begin
        wptr_d  = AW'(0);
        rptr_d  = AW'(0);
        count_d = AW'(0);
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= AW'(0);
      rptr_q  <= AW'(0);
      count_q <= AW'(0);
      out_q   <= 16'h0000;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_s) begin
      mem[wptr_q] <= q_in_s;
    end
  end

  assign output_port = out_q;
  assign valid       = valid_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign count       = count_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Self-checking bench for conv_result_streamer: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_conv_result_streamer;
  localparam int DEPTH = 100;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   in_data;
  logic          in_invalid;
  logic          in_finish;
  logic          out_ready;
  logic [15:0]   output_port;
  logic          valid;
  logic          done;
  logic          overflow;
  logic [AW-1:0] count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          frame_n  = 0;
  bit          exp_ovf  = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data  = 16'h0000;
  int          vc;
  bit          gd;

  conv_result_streamer #(.DEPTH(DEPTH), .SHIFT(8), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_invalid(in_invalid),
    .in_finish(in_finish), .out_ready(out_ready), .output_port(output_port),
    .valid(valid), .done(done), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference requantizer: floor division by 256, optional ReLU, clamp to int16.
  function automatic logic [15:0] model_q(input logic [31:0] d);
    longint v, q;
    v = longint'($signed(d));
    q = v / 256;
    if (v < 0 && (v % 256) != 0) q = q - 1;
`ifdef RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  // Compare process: every valid cycle must present the oldest undelivered model word.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && prev_stall) begin
        check("stall_hold_valid", 32'(valid), 32'd1);
        check("stall_hold_data", 32'(output_port), 32'(prev_data));
      end
      if (reset && valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(valid), 32'd0);
        end else begin
          check("pixel", 32'(output_port), 32'(exp_q[0]));
          if (out_ready) begin
            got_q.push_back(output_port);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_stall = reset && valid && !out_ready;
      prev_data  = output_port;
    end
  end

  task automatic send(input logic [31:0] d, input logic fin);
    in_data = d; in_invalid = 1'b0; in_finish = fin;
    if (frame_n < DEPTH) begin
      exp_q.push_back(model_q(d));
      frame_n++;
    end else begin
      exp_ovf = 1'b1;
    end
    @(posedge clk); #1;
    in_invalid = 1'b1; in_finish = 1'b0; in_data = 32'd0;
  endtask

  task automatic finish_only();
    in_finish = 1'b1;
    @(posedge clk); #1;
    in_finish = 1'b0;
  endtask

  task automatic run_drain(input logic [15:0] pat, input int patlen, input int budget,
                           output int vcyc, output bit got_done);
    vcyc = 0; got_done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      out_ready = (c < patlen) ? pat[c] : 1'b1;
      @(negedge clk);
      if (valid) vcyc++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    frame_n = 0;
  endtask

  task automatic end_frame(input string nm, input int vcyc, input bit got_done, input int exp_vc);
    check({nm, "_done_seen"}, 32'(got_done), 32'd1);
    check({nm, "_valid_cycles"}, 32'(vcyc), 32'(exp_vc));
    check({nm, "_all_drained"}, 32'(exp_q.size()), 32'd0);
    check({nm, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    check({nm, "_done_single"}, 32'(done), 32'd0);
    check({nm, "_count_cleared"}, 32'(count), 32'd0);
  endtask

  initial begin
    reset = 1'b0; in_data = 32'd0; in_invalid = 1'b1; in_finish = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_data", 32'(output_port), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Finish with nothing buffered: done one cycle later, no valid.
    finish_only();
    @(negedge clk);
    check("empty_done", 32'(done), 32'd1);
    check("empty_valid", 32'(valid), 32'd0);
    @(posedge clk); #1;
    check("empty_done_drop", 32'(done), 32'd0);

    // Full capture of 100 words.
    got_q.delete();
    for (int k = 0; k < DEPTH; k++) send(32'(k * 256), 1'b0);
    @(negedge clk);
    check("full_count", 32'(count), 32'd100);
    check("full_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    finish_only();
    run_drain(16'h0000, 0, 400, vc, gd);
    end_frame("full", vc, gd, 100);
    check("full_got_n", 32'(got_q.size()), 32'd100);
    if (got_q.size() == 100) begin
      check("full_first", 32'(got_q[0]), 32'h0000);
      check("full_last", 32'(got_q[99]), 32'd99);
    end

    // Saturation and sign.
    got_q.delete();
    send(32'h7FFFFF00, 1'b0);
    send(32'hFF000000, 1'b0);
    send(32'hFFFFFF80, 1'b0);
    finish_only();
    run_drain(16'h0000, 0, 50, vc, gd);
    end_frame("sat", vc, gd, 3);
    check("sat_got_n", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("sat_pos", 32'(got_q[0]), 32'h7FFF);
`ifdef RELU_EN
      check("sat_neg", 32'(got_q[1]), 32'h0000);
      check("sat_m1", 32'(got_q[2]), 32'h0000);
`else
      check("sat_neg", 32'(got_q[1]), 32'h8000);
      check("sat_m1", 32'(got_q[2]), 32'hFFFF);
`endif
    end

    // Backpressure: ready pattern 1,0,0,1,1,0,1.
    got_q.delete();
    send(32'h00001100, 1'b0);
    send(32'hFFFFFD00, 1'b0);
    send(32'h00123400, 1'b0);
    send(32'h00000280, 1'b0);
    finish_only();
    run_drain(16'b0000000001011001, 7, 50, vc, gd);
    end_frame("bp", vc, gd, 7);
    check("bp_got_n", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      check("bp_w0", 32'(got_q[0]), 32'h0011);
      check("bp_w2", 32'(got_q[2]), 32'h1234);
      check("bp_w3", 32'(got_q[3]), 32'h0002);
    end

    // Overflow: 105 words, only the first 100 survive.
    got_q.delete();
    for (int k = 0; k < 105; k++) send(32'((k + 200) * 256), 1'b0);
    @(negedge clk);
    check("ovf_count", 32'(count), 32'd100);
    check("ovf_flag", 32'(overflow), 32'd1);
    @(posedge clk); #1;
    finish_only();
    run_drain(16'h0000, 0, 400, vc, gd);
    end_frame("ovf", vc, gd, 100);
    check("ovf_got_n", 32'(got_q.size()), 32'd100);
    if (got_q.size() == 100) check("ovf_last", 32'(got_q[99]), 32'd299);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Word captured in the finish cycle.
    got_q.delete();
    send(32'h00000300, 1'b0);
    send(32'h00000400, 1'b0);
    send(32'h00000500, 1'b1);
    run_drain(16'h0000, 0, 50, vc, gd);
    end_frame("fin", vc, gd, 3);
    check("fin_got_n", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) check("fin_last", 32'(got_q[2]), 32'h0005);

    // Single word arriving with finish into an empty buffer.
    got_q.delete();
    send(32'h00000700, 1'b1);
    run_drain(16'h0000, 0, 50, vc, gd);
    end_frame("solo", vc, gd, 1);
    if (got_q.size() == 1) check("solo_word", 32'(got_q[0]), 32'h0007);
    else check("solo_got_n", 32'(got_q.size()), 32'd1);

    // Asynchronous reset in the middle of a drain.
    for (int k = 0; k < 10; k++) send(32'((k + 40) * 256), 1'b0);
    finish_only();
    repeat (3) @(negedge clk);
    check("mid_pre_valid", 32'(valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_data", 32'(output_port), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    exp_q.delete(); exp_ovf = 1'b0; frame_n = 0;
    #3 reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("mid_no_done", 32'(done), 32'd0);
      check("mid_no_valid", 32'(valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
